// File: rtl/led_pattern_sequencer.sv
// Four-LED animation sequencer: button synchroniser/debouncer, step-rate prescaler,
// and a mode state machine cycling OFF -> BLINK -> CHASE -> BOUNCE.
module led_pattern_sequencer #(
    parameter int CLK_HZ          = 12000000,
    parameter int STEP_HZ         = 4,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    input  logic       EN,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic [1:0] MODE,
    output logic       STEP
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int PRE_W    = $clog2(STEP_DIV);
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BLINK  = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_t;

    logic            btn_p0;
    logic            btn_p1;
    logic            btn_acc;
    logic [DB_W-1:0] db_cnt;
    logic            press_p2;

    mode_t           mode_q;
    mode_t           mode_d;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [3:0]       pat_q;
    logic [3:0]       pat_d;
    logic             dir_q;
    logic             dir_d;
    logic             step_q;
    logic             step_d;
    logic             tick;

    // Stage p0/p1: two-flop synchroniser; p2: debounce and press detection.
    // The counter runs only while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the hold time.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_p0   <= 1'b0;
            btn_p1   <= 1'b0;
            btn_acc  <= 1'b0;
            db_cnt   <= '0;
            press_p2 <= 1'b0;
        end else begin
            btn_p0   <= BTN;
            btn_p1   <= btn_p0;
            press_p2 <= 1'b0;
            if (btn_p1 == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                btn_acc  <= btn_p1;
                press_p2 <= btn_p1;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Mode state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= M_OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next-state: one advance per accepted press.
    always_comb begin
        mode_d = mode_q;
        if (press_p2) begin
            case (mode_q)
                M_OFF:    mode_d = M_BLINK;
                M_BLINK:  mode_d = M_CHASE;
                M_CHASE:  mode_d = M_BOUNCE;
                default:  mode_d = M_OFF;
            endcase
        end
    end

    assign tick = EN && (pre_q == PRE_LAST);

    // Pattern/prescaler next values. A press takes priority and swallows a coincident tick.
    always_comb begin
        pre_d  = pre_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (press_p2) begin
            pre_d = '0;
            dir_d = DIR_UP;
            case (mode_d)
                M_CHASE, M_BOUNCE: pat_d = 4'b0001;
                default:           pat_d = 4'b0000;
            endcase
        end else if (EN) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                case (mode_q)
                    M_BLINK: begin
                        pat_d  = ~pat_q;
                        step_d = 1'b1;
                    end
                    M_CHASE: begin
                        pat_d  = {pat_q[2:0], pat_q[3]};
                        step_d = 1'b1;
                    end
                    M_BOUNCE: begin
                        step_d = 1'b1;
                        if (dir_q == DIR_UP) begin
                            pat_d = {pat_q[2:0], 1'b0};
                            if (pat_q == 4'b0100) dir_d = DIR_DN;
                        end else begin
                            pat_d = {1'b0, pat_q[3:1]};
                            if (pat_q == 4'b0010) dir_d = DIR_UP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output stage: registered pattern, direction, prescaler and step pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q  <= '0;
            pat_q  <= 4'b0000;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign {LED3, LED2, LED1, LED0} = pat_q;
    assign MODE = mode_q;
    assign STEP = step_q;

endmodule
